// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the pipeline hazard controller.
// Ports: none (package). Provides bypass-select encodings, mul/div state enum
// and default parameter values.
package hazard_pkg;

   // Bypass mux select encodings for the E-stage operand muxes.
   localparam logic [1:0] FWD_RF  = 2'b00;   // register-file value
   localparam logic [1:0] FWD_WB  = 2'b01;   // result from W
   localparam logic [1:0] FWD_MEM = 2'b10;   // result from M

   // Mul/div tracker state.
   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   localparam int MD_LAT_DEF = 32;
   localparam int RW_DEF     = 5;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the pipeline datapath and hazard_ctrl.
// Ports: master = pipeline side (drives register indices, stage flags, memory
// handshake; receives enables/clears/bypass selects); slave = controller side.
interface hazard_ctrl_if #(
   parameter int RW = 5
);

   // Register indices per stage
   logic [RW-1:0] rsD, rtD;
   logic [RW-1:0] rsE, rtE;
   logic [RW-1:0] writeregE, writeregM, writeregW;

   // Stage control flags
   logic regwriteE, regwriteM, regwriteW;
   logic memtoregE, memtoregM;
   logic branchD, pcsrcD;
   logic mdstartE, mdreadE;

   // Data-memory handshake
   logic dmem_reqM, dmem_readyM;

   // Controller outputs
   logic enF, enD, enE, enM;
   logic clrD, clrE, clrM, clrW;
   logic fwdAD, fwdBD;
   logic [1:0] fwdAE, fwdBE;
   logic md_busy;

   modport master (
      output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
      output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
      output branchD, pcsrcD, mdstartE, mdreadE, dmem_reqM, dmem_readyM,
      input  enF, enD, enE, enM, clrD, clrE, clrM, clrW,
      input  fwdAD, fwdBD, fwdAE, fwdBE, md_busy
   );

   modport slave (
      input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
      input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
      input  branchD, pcsrcD, mdstartE, mdreadE, dmem_reqM, dmem_readyM,
      output enF, enD, enE, enM, clrD, clrE, clrM, clrW,
      output fwdAD, fwdBD, fwdAE, fwdBE, md_busy
   );

endinterface

// File: rtl/hazard_ctrl_md_tracker.sv
// md_tracker: tracks occupancy of the multi-cycle mul/div unit.
// Latency: md_busy rises the cycle after an accepted start, stays high MD_LAT cycles.
// Backpressure: a start is not accepted while hold is high or while already busy.
// Ports: clk, reset (sync, active-low), mdstartE (E issues mul/div),
//        hold (memory wait freezes acceptance), md_busy (unit occupied).
module md_tracker
   import hazard_pkg::*;
#(
   parameter int MD_LAT = MD_LAT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic mdstartE,
   input  logic hold,
   output logic md_busy
);

   localparam int CW = $clog2(MD_LAT);

   md_state_t     state, state_nxt;
   logic [CW-1:0] count, count_nxt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= MD_IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   // Count runs MD_LAT-1 down to 0 while BUSY, giving exactly MD_LAT busy
   // cycles. It keeps running through memory waits because the unit itself
   // is never stalled; only new starts are held off.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      case (state)
         MD_IDLE: begin
            if (mdstartE && !hold) begin
               state_nxt = MD_BUSY;
               count_nxt = CW'(MD_LAT - 1);
            end
         end
         MD_BUSY: begin
            if (count == '0) begin
               state_nxt = MD_IDLE;
            end else begin
               count_nxt = count - CW'(1);
            end
         end
         default: begin
            state_nxt = MD_IDLE;
            count_nxt = '0;
         end
      endcase
   end

   assign md_busy = reset && (state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward controller for the 5-stage F/D/E/M/W pipeline.
// Latency: all outputs combinational from inputs and mul/div tracker state.
// Backpressure: memory wait > mul/div structural stall > load-use/branch stall > taken-branch flush.
// Ports: clk, reset (sync, active-low), hz (slave side of hazard_ctrl_if).
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int RW     = RW_DEF,
   parameter int MD_LAT = MD_LAT_DEF
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave hz
);

   localparam logic [RW-1:0] R0 = '0;

   logic md_busy;
   logic memwait, mdstall, lwstall, brstall;

   // Writer-valid terms: a stage that writes a non-zero register.
   logic wr_e, wr_m, wr_w, ld_e, ld_m;
   assign wr_e = hz.regwriteE && (hz.writeregE != R0);
   assign wr_m = hz.regwriteM && (hz.writeregM != R0);
   assign wr_w = hz.regwriteW && (hz.writeregW != R0);
   assign ld_e = hz.memtoregE && (hz.writeregE != R0);
   assign ld_m = hz.memtoregM && (hz.writeregM != R0);

   logic e_hits_d, m_hits_d;
   assign e_hits_d = (hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD);
   assign m_hits_d = (hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD);

   assign memwait = hz.dmem_reqM && !hz.dmem_readyM;
   assign lwstall = ld_e && e_hits_d;
   // Branch compares in D, so it must wait for an E ALU result or an M load.
   assign brstall = hz.branchD && ((wr_e && e_hits_d) || (ld_m && m_hits_d));
   assign mdstall = md_busy && (hz.mdreadE || hz.mdstartE);

   md_tracker #(
      .MD_LAT (MD_LAT)
   ) u_md (
      .clk      (clk),
      .reset    (reset),
      .mdstartE (hz.mdstartE),
      .hold     (memwait),
      .md_busy  (md_busy)
   );

   logic [3:0] en;    // {F, D, E, M}
   logic [3:0] clr;   // {D, E, M, W}
   logic [1:0] fwd_ae, fwd_be;
   logic       fwd_ad, fwd_bd;

   always_comb begin
      en     = 4'b1111;
      clr    = 4'b0000;
      fwd_ae = FWD_RF;
      fwd_be = FWD_RF;
      fwd_ad = 1'b0;
      fwd_bd = 1'b0;

      if (reset) begin
         // M has priority over W: it holds the younger value.
         if (wr_m && (hz.writeregM == hz.rsE))      fwd_ae = FWD_MEM;
         else if (wr_w && (hz.writeregW == hz.rsE)) fwd_ae = FWD_WB;

         if (wr_m && (hz.writeregM == hz.rtE))      fwd_be = FWD_MEM;
         else if (wr_w && (hz.writeregW == hz.rtE)) fwd_be = FWD_WB;

         fwd_ad = wr_m && (hz.writeregM == hz.rsD);
         fwd_bd = wr_m && (hz.writeregM == hz.rtD);

         if (memwait) begin
            // Whole pipe frozen; W is bubbled so the stalled M result is
            // not written twice.
            en  = 4'b0000;
            clr = 4'b0001;
         end else if (mdstall) begin
            en  = 4'b0001;
            clr = 4'b0010;
         end else if (lwstall || brstall) begin
            // pcsrcD is not trustworthy while D waits for its operands, so
            // D is never flushed here.
            en  = 4'b0011;
            clr = 4'b0100;
         end else if (hz.pcsrcD) begin
            clr = 4'b1000;
         end
      end
   end

   assign hz.enF    = en[3];
   assign hz.enD    = en[2];
   assign hz.enE    = en[1];
   assign hz.enM    = en[0];
   assign hz.clrD   = clr[3];
   assign hz.clrE   = clr[2];
   assign hz.clrM   = clr[1];
   assign hz.clrW   = clr[0];
   assign hz.fwdAE  = fwd_ae;
   assign hz.fwdBE  = fwd_be;
   assign hz.fwdAD  = fwd_ad;
   assign hz.fwdBD  = fwd_bd;
   assign hz.md_busy = md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl with a per-cycle reference model.
// Ports: none (top-level bench).
module tb_hazard_ctrl;

   localparam int RW     = 5;
   localparam int MD_LAT = 4;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   int   md_rem = 0;     // model: busy cycles still to come (0 = unit free)

   hazard_ctrl_if #(.RW(RW)) hif ();

   hazard_ctrl #(
      .RW     (RW),
      .MD_LAT (MD_LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hif)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic m_hit(input logic wen, input logic [RW-1:0] dst,
                                  input logic [RW-1:0] src);
      return wen && (dst != 0) && (dst == src);
   endfunction

   function automatic logic [14:0] model_out();
      logic [3:0] en, clr;
      logic [1:0] fae, fbe;
      logic       fad, fbd, lw, br, mw, ms;
      if (!reset) return {4'b1111, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0};
      fae = m_hit(hif.regwriteM, hif.writeregM, hif.rsE) ? 2'd2 :
            m_hit(hif.regwriteW, hif.writeregW, hif.rsE) ? 2'd1 : 2'd0;
      fbe = m_hit(hif.regwriteM, hif.writeregM, hif.rtE) ? 2'd2 :
            m_hit(hif.regwriteW, hif.writeregW, hif.rtE) ? 2'd1 : 2'd0;
      fad = m_hit(hif.regwriteM, hif.writeregM, hif.rsD);
      fbd = m_hit(hif.regwriteM, hif.writeregM, hif.rtD);
      lw  = m_hit(hif.memtoregE, hif.writeregE, hif.rsD) ||
            m_hit(hif.memtoregE, hif.writeregE, hif.rtD);
      br  = hif.branchD &&
            (m_hit(hif.regwriteE, hif.writeregE, hif.rsD) ||
             m_hit(hif.regwriteE, hif.writeregE, hif.rtD) ||
             m_hit(hif.memtoregM, hif.writeregM, hif.rsD) ||
             m_hit(hif.memtoregM, hif.writeregM, hif.rtD));
      mw  = hif.dmem_reqM && !hif.dmem_readyM;
      ms  = (md_rem > 0) && (hif.mdreadE || hif.mdstartE);
      if (mw)            begin en = 4'b0000; clr = 4'b0001; end
      else if (ms)       begin en = 4'b0001; clr = 4'b0010; end
      else if (lw || br) begin en = 4'b0011; clr = 4'b0100; end
      else if (hif.pcsrcD) begin en = 4'b1111; clr = 4'b1000; end
      else               begin en = 4'b1111; clr = 4'b0000; end
      return {en, clr, fad, fbd, fae, fbe, (md_rem > 0)};
   endfunction

   always @(posedge clk) begin
      if (!reset)           md_rem <= 0;
      else if (md_rem > 0)  md_rem <= md_rem - 1;
      else if (hif.mdstartE && !(hif.dmem_reqM && !hif.dmem_readyM))
                            md_rem <= MD_LAT;
   end

   function automatic logic [14:0] dut_out();
      return {hif.enF, hif.enD, hif.enE, hif.enM,
              hif.clrD, hif.clrE, hif.clrM, hif.clrW,
              hif.fwdAD, hif.fwdBD, hif.fwdAE, hif.fwdBE, hif.md_busy};
   endfunction

   always @(negedge clk) begin
      logic [14:0] exp_v, got_v;
      exp_v = model_out();
      got_v = dut_out();
      tests++;
      if (got_v !== exp_v) begin
         fails++;
         $display("FAIL model @%0t: got %h expected %h", $time, got_v, exp_v);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] enclr();
      return {24'b0, hif.enF, hif.enD, hif.enE, hif.enM,
              hif.clrD, hif.clrE, hif.clrM, hif.clrW};
   endfunction

   function automatic logic [31:0] fwdv();
      return {26'b0, hif.fwdAD, hif.fwdBD, hif.fwdAE, hif.fwdBE};
   endfunction

   function automatic logic [31:0] busyv();
      return {31'b0, hif.md_busy};
   endfunction

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic idle_in();
      hif.rsD = '0; hif.rtD = '0; hif.rsE = '0; hif.rtE = '0;
      hif.writeregE = '0; hif.writeregM = '0; hif.writeregW = '0;
      hif.regwriteE = 0; hif.regwriteM = 0; hif.regwriteW = 0;
      hif.memtoregE = 0; hif.memtoregM = 0;
      hif.branchD = 0; hif.pcsrcD = 0;
      hif.mdstartE = 0; hif.mdreadE = 0;
      hif.dmem_reqM = 0; hif.dmem_readyM = 0;
   endtask

   // Counts consecutive md_busy cycles starting from the current cycle.
   task automatic busy_run(output int n);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         neg();
         if (hif.md_busy) n++;
         else if (n > 0) break;
         nxt();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      reset = 1'b0;
      idle_in();
      // Hazard-looking inputs during reset must be ignored.
      hif.dmem_reqM = 1; hif.mdstartE = 1; hif.regwriteM = 1;
      hif.writeregM = 3; hif.rsE = 3; hif.rsD = 3;
      neg();
      chk("rst_enclr", enclr(), 32'hF0);
      chk("rst_fwd",   fwdv(),  32'h00);
      chk("rst_busy",  busyv(), 32'h0);

      nxt(); reset = 1'b1; idle_in();
      neg();
      chk("idle_enclr", enclr(), 32'hF0);
      chk("idle_busy",  busyv(), 32'h0);

      // Load-use stall, then M forward
      nxt(); idle_in(); hif.memtoregE = 1; hif.writeregE = 2; hif.rsD = 2;
      neg(); chk("lu_stall", enclr(), 32'h34);
      nxt(); idle_in(); hif.regwriteM = 1; hif.writeregM = 2; hif.rsE = 2;
      neg(); chk("lu_fwd", fwdv(), 32'h08);
      chk("lu_free", enclr(), 32'hF0);

      // Forward priority
      nxt(); idle_in();
      hif.regwriteM = 1; hif.regwriteW = 1; hif.writeregM = 3; hif.writeregW = 3;
      hif.rsE = 3; hif.rtE = 3; hif.rsD = 3; hif.rtD = 3;
      neg(); chk("fwd_m_prio", fwdv(), 32'h3A);
      nxt(); hif.writeregM = 0;
      neg(); chk("fwd_w", fwdv(), 32'h05);
      nxt(); hif.writeregW = 0; hif.rsE = 0; hif.rtE = 0;
      neg(); chk("fwd_r0", fwdv(), 32'h00);

      // Mul/div with mfhi/mflo waiting
      nxt(); idle_in(); hif.mdstartE = 1;
      neg(); chk("md_start_idle", busyv(), 32'h0);
      nxt(); hif.mdstartE = 0; hif.mdreadE = 1;
      for (int i = 0; i < MD_LAT; i++) begin
         neg();
         chk("md_rd_busy",  busyv(), 32'h1);
         chk("md_rd_stall", enclr(), 32'h12);
         nxt();
      end
      neg();
      chk("md_rd_done_busy", busyv(), 32'h0);
      chk("md_rd_done_en",   enclr(), 32'hF0);

      // Back-to-back mul/div: second one stalls then is accepted
      nxt(); idle_in(); hif.mdstartE = 1;
      neg();
      nxt();
      for (int i = 0; i < MD_LAT; i++) begin
         neg();
         chk("md2_stall", enclr(), 32'h12);
         nxt();
      end
      neg();
      chk("md2_accept_busy", busyv(), 32'h0);
      chk("md2_accept_en",   enclr(), 32'hF0);
      nxt(); idle_in();
      busy_run(n);
      chk("md2_len", n, 32'd4);

      // Start held by memory wait, then count runs through a memory wait
      nxt(); idle_in(); hif.mdstartE = 1; hif.dmem_reqM = 1;
      for (int i = 0; i < 2; i++) begin
         neg();
         chk("mdh_busy", busyv(), 32'h0);
         chk("mdh_act",  enclr(), 32'h01);
         nxt();
      end
      hif.dmem_reqM = 0;
      neg(); chk("mdh_release", busyv(), 32'h0);
      nxt(); hif.mdstartE = 0;
      neg(); chk("mdh_b1", busyv(), 32'h1);
      nxt(); hif.dmem_reqM = 1;
      neg(); chk("mdh_b2", busyv(), 32'h1);
      nxt();
      neg(); chk("mdh_b3", busyv(), 32'h1);
      nxt(); hif.dmem_reqM = 0;
      neg(); chk("mdh_b4", busyv(), 32'h1);
      nxt();
      neg(); chk("mdh_end", busyv(), 32'h0);

      // Memory wait outranks load-use
      nxt(); idle_in(); hif.memtoregE = 1; hif.writeregE = 7; hif.rtD = 7;
      hif.dmem_reqM = 1;
      for (int i = 0; i < 3; i++) begin
         neg();
         chk("mw_act", enclr(), 32'h01);
         nxt();
      end
      hif.dmem_readyM = 1;
      neg(); chk("mw_then_lw", enclr(), 32'h34);

      // Branches
      nxt(); idle_in(); hif.pcsrcD = 1;
      neg(); chk("br_taken", enclr(), 32'hF8);
      nxt(); idle_in();
      neg(); chk("br_after", enclr(), 32'hF0);
      nxt(); hif.branchD = 1; hif.pcsrcD = 1; hif.regwriteE = 1;
      hif.writeregE = 5; hif.rsD = 5;
      neg(); chk("br_stall_e", enclr(), 32'h34);
      nxt(); idle_in(); hif.branchD = 1; hif.memtoregM = 1;
      hif.writeregM = 6; hif.rtD = 6;
      neg(); chk("br_stall_m", enclr(), 32'h34);
      nxt(); idle_in(); hif.branchD = 1; hif.pcsrcD = 1; hif.regwriteE = 1;
      neg(); chk("br_r0_taken", enclr(), 32'hF8);

      // Reset in the middle of BUSY
      nxt(); idle_in(); hif.mdstartE = 1;
      nxt(); idle_in();
      neg(); chk("rb_b1", busyv(), 32'h1);
      nxt(); reset = 1'b0; hif.mdreadE = 1;
      neg();
      chk("rb_rst_busy", busyv(), 32'h0);
      chk("rb_rst_en",   enclr(), 32'hF0);
      nxt(); reset = 1'b1;
      neg();
      chk("rb_after_busy", busyv(), 32'h0);
      chk("rb_after_en",   enclr(), 32'hF0);
      nxt(); idle_in(); hif.mdstartE = 1;
      nxt(); hif.mdstartE = 0;
      busy_run(n);
      chk("rb_full_len", n, 32'd4);

      nxt(); nxt();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
